// File: rtl/rr_arbiter32_pkg.sv
// Shared constants and types for the 32-way round-robin result arbiter.
package rr_arbiter32_pkg;

    localparam int WORD_LENGTH = 32;
    localparam int NUM_REQ     = 32;
    localparam int SEL_W       = 5;

    typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_t;

endpackage

// File: rtl/rr_arbiter32_if.sv
// Request side (32 producers) and output side (one consumer) of the arbiter.
interface rr_arbiter32_if
    import rr_arbiter32_pkg::*;
#(
    parameter int n = WORD_LENGTH
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0][n-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [n-1:0]              out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_ready;

    // Arbiter side
    modport master (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_sel
    );

    // Producer/consumer side
    modport slave (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_arbiter32_mux.sv
// Plain 32-input word multiplexer; dout follows in[sel] combinationally.
module mux32 #(
    parameter int n = 32
) (
    input  logic [n-1:0] in00, input  logic [n-1:0] in01,
    input  logic [n-1:0] in02, input  logic [n-1:0] in03,
    input  logic [n-1:0] in04, input  logic [n-1:0] in05,
    input  logic [n-1:0] in06, input  logic [n-1:0] in07,
    input  logic [n-1:0] in08, input  logic [n-1:0] in09,
    input  logic [n-1:0] in10, input  logic [n-1:0] in11,
    input  logic [n-1:0] in12, input  logic [n-1:0] in13,
    input  logic [n-1:0] in14, input  logic [n-1:0] in15,
    input  logic [n-1:0] in16, input  logic [n-1:0] in17,
    input  logic [n-1:0] in18, input  logic [n-1:0] in19,
    input  logic [n-1:0] in20, input  logic [n-1:0] in21,
    input  logic [n-1:0] in22, input  logic [n-1:0] in23,
    input  logic [n-1:0] in24, input  logic [n-1:0] in25,
    input  logic [n-1:0] in26, input  logic [n-1:0] in27,
    input  logic [n-1:0] in28, input  logic [n-1:0] in29,
    input  logic [n-1:0] in30, input  logic [n-1:0] in31,
    input  logic [4:0]   sel,
    output logic [n-1:0] dout
);
    logic [31:0][n-1:0] ins;

    assign ins = {in31, in30, in29, in28, in27, in26, in25, in24,
                  in23, in22, in21, in20, in19, in18, in17, in16,
                  in15, in14, in13, in12, in11, in10, in09, in08,
                  in07, in06, in05, in04, in03, in02, in01, in00};

    assign dout = ins[sel];
endmodule

// File: rtl/rr_arbiter32_pick.sv
// Round-robin pick: first set bit of req searching upward from ptr, wrapping at 32.
module rr_pick32
    import rr_arbiter32_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   grant,
    output logic [NUM_REQ-1:0] grant_oh
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     idx;

    // Rotating right by ptr puts requester ptr at bit 0, so the lowest set bit wins.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NUM_REQ-1:0];

    always_comb begin
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) idx = i[SEL_W-1:0];
        end
    end

    assign any      = |req;
    assign grant    = idx + ptr;
    assign grant_oh = any ? (NUM_REQ'(1) << grant) : '0;
endmodule

// File: rtl/rr_arbiter32.sv
// 32-way round-robin arbiter feeding a one-entry output register with valid/ready.
module rr_arbiter32
    import rr_arbiter32_pkg::*;
#(
    parameter int n = WORD_LENGTH
) (
    input logic          clk,
    input logic          reset,
    rr_arbiter32_if.master bus
);
    arb_state_t         state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [n-1:0]       data_q, data_d;
    logic [SEL_W-1:0]   sel_q, sel_d;

    logic               any;
    logic [SEL_W-1:0]   grant;
    logic [NUM_REQ-1:0] grant_oh;
    logic [n-1:0]       mux_word;
    logic               can_accept;
    logic               accept;

    rr_pick32 u_pick (
        .req      (bus.req_valid),
        .ptr      (ptr_q),
        .any      (any),
        .grant    (grant),
        .grant_oh (grant_oh)
    );

    mux32 #(.n(n)) u_mux (
        .in00(bus.req_data[0]),  .in01(bus.req_data[1]),
        .in02(bus.req_data[2]),  .in03(bus.req_data[3]),
        .in04(bus.req_data[4]),  .in05(bus.req_data[5]),
        .in06(bus.req_data[6]),  .in07(bus.req_data[7]),
        .in08(bus.req_data[8]),  .in09(bus.req_data[9]),
        .in10(bus.req_data[10]), .in11(bus.req_data[11]),
        .in12(bus.req_data[12]), .in13(bus.req_data[13]),
        .in14(bus.req_data[14]), .in15(bus.req_data[15]),
        .in16(bus.req_data[16]), .in17(bus.req_data[17]),
        .in18(bus.req_data[18]), .in19(bus.req_data[19]),
        .in20(bus.req_data[20]), .in21(bus.req_data[21]),
        .in22(bus.req_data[22]), .in23(bus.req_data[23]),
        .in24(bus.req_data[24]), .in25(bus.req_data[25]),
        .in26(bus.req_data[26]), .in27(bus.req_data[27]),
        .in28(bus.req_data[28]), .in29(bus.req_data[29]),
        .in30(bus.req_data[30]), .in31(bus.req_data[31]),
        .sel (grant),
        .dout(mux_word)
    );

    // A full register can still take a word when the consumer drains it this cycle.
    assign can_accept = (state_q == ARB_EMPTY) || bus.out_ready;
    assign accept     = can_accept && any && !reset;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        data_d        = data_q;
        sel_d         = sel_q;
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready = grant_oh;
            state_d       = ARB_FULL;
            ptr_d         = grant + SEL_W'(1);
            data_d        = mux_word;
            sel_d         = grant;
        end else if (state_q == ARB_FULL && bus.out_ready) begin
            state_d = ARB_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.out_valid = (state_q == ARB_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_rr_arbiter32.sv
// Directed scenarios plus a cycle monitor that scoreboards every grant against a reference arbiter.
module tb_rr_arbiter32;
    import rr_arbiter32_pkg::*;

    localparam int N = WORD_LENGTH;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [N-1:0]     data;
    } item_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    item_t            q[$];
    logic [SEL_W-1:0] mptr;

    rr_arbiter32_if #(.n(N)) bus ();

    rr_arbiter32 #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [SEL_W-1:0] mpick(input logic [31:0] v, input logic [SEL_W-1:0] p);
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [SEL_W-1:0] j;
            j = SEL_W'(p + k);
            if (v[j]) return j;
        end
        return '0;
    endfunction

    // Reference model, evaluated mid-cycle and advanced for the coming edge.
    always @(negedge clk) begin
        logic             full, can, any;
        logic [SEL_W-1:0] g;
        logic [31:0]      exp_rr;
        if (reset) begin
            chk("mon_rr_in_reset", 64'(bus.req_ready), 64'd0);
            q.delete();
            mptr = '0;
        end else begin
            full = (q.size() != 0);
            chk("mon_out_valid", 64'(bus.out_valid), 64'(full));
            if (full) begin
                chk("mon_out_sel", 64'(bus.out_sel), 64'(q[0].sel));
                chk("mon_out_data", 64'(bus.out_data), 64'(q[0].data));
            end
            can    = !full || bus.out_ready;
            any    = |bus.req_valid;
            g      = mpick(bus.req_valid, mptr);
            exp_rr = (can && any) ? (32'd1 << g) : 32'd0;
            chk("mon_req_ready", 64'(bus.req_ready), 64'(exp_rr));
            if (full && bus.out_ready) void'(q.pop_front());
            if (can && any) begin
                q.push_back('{sel: g, data: bus.req_data[g]});
                mptr = g + SEL_W'(1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        bus.req_valid = 32'hFFFF_FFFF;
        for (int k = 0; k < NUM_REQ; k++) bus.req_data[k] = N'(32'hD000_0000 | k);

        // 1: reset with every requester valid
        repeat (2) begin
            #3 chk("t1_rr_in_reset", 64'(bus.req_ready), 64'd0);
            cyc();
        end
        #3;
        chk("t1_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t1_out_data", 64'(bus.out_data), 64'd0);
        chk("t1_out_sel", 64'(bus.out_sel), 64'd0);
        cyc();
        reset = 1'b0;

        // 2: single requester
        bus.req_valid   = 32'h0000_0020;
        bus.req_data[5] = N'(32'hA5);
        bus.out_ready   = 1'b1;
        #3 chk("t2_req_ready", 64'(bus.req_ready), 64'h20);
        cyc();
        bus.req_valid = '0;
        #3;
        chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_out_sel", 64'(bus.out_sel), 64'd5);
        chk("t2_out_data", 64'(bus.out_data), 64'hA5);
        cyc();

        // 3: fairness with all valid, continuous drain
        do_reset();
        bus.req_valid = 32'hFFFF_FFFF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            #3;
            chk("t3_out_valid", 64'(bus.out_valid), 64'd1);
            chk("t3_out_sel", 64'(bus.out_sel), 64'(i % 32));
        end
        bus.req_valid = '0;
        cyc();
        cyc();

        // 4: backpressure while holding sel 2
        do_reset();
        bus.req_valid = 32'h0000_0004;
        cyc();
        bus.req_valid = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("t4_rr_stall", 64'(bus.req_ready), 64'd0);
            chk("t4_sel_hold", 64'(bus.out_sel), 64'd2);
            chk("t4_data_hold", 64'(bus.out_data), 64'hD000_0002);
            cyc();
        end
        bus.out_ready = 1'b1;
        #3 chk("t4_rr_release", 64'(bus.req_ready), 64'h200);
        cyc();
        bus.req_valid = '0;
        #3 chk("t4_sel_next", 64'(bus.out_sel), 64'd9);
        cyc();

        // 5: pointer wrap
        do_reset();
        bus.req_valid = 32'h8000_0000;
        bus.out_ready = 1'b1;
        cyc();
        bus.req_valid = 32'h4000_0008;
        #3 chk("t5_sel31", 64'(bus.out_sel), 64'd31);
        cyc();
        #3 chk("t5_sel3a", 64'(bus.out_sel), 64'd3);
        cyc();
        #3 chk("t5_sel30", 64'(bus.out_sel), 64'd30);
        cyc();
        #3 chk("t5_sel3b", 64'(bus.out_sel), 64'd3);
        bus.req_valid = '0;
        cyc();

        // 6: reset while full
        do_reset();
        bus.req_valid = 32'h0000_1000;
        bus.out_ready = 1'b0;
        cyc();
        bus.req_valid = 32'hFFFF_FFFF;
        #3;
        chk("t6_full_sel", 64'(bus.out_sel), 64'd12);
        chk("t6_full_valid", 64'(bus.out_valid), 64'd1);
        cyc();
        reset = 1'b1;
        #3 chk("t6_rr_in_reset", 64'(bus.req_ready), 64'd0);
        cyc();
        reset = 1'b0;
        #3;
        chk("t6_valid_cleared", 64'(bus.out_valid), 64'd0);
        chk("t6_first_grant", 64'(bus.req_ready), 64'd1);
        bus.out_ready = 1'b1;
        cyc();
        #3 chk("t6_sel0", 64'(bus.out_sel), 64'd0);
        bus.req_valid = '0;
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
